lighting_ctrl_seq: RTL and testbench

//  Clocked, parametrised successor of the combinational LightingSystem controller.

---
 rtl/lighting_ctrl_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_lighting_ctrl_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lighting_ctrl_seq.sv
// ---------------------------------------------------------------------------
// lighting_ctrl_seq
//
// Clocked lighting/shade controller. A one-hot time code, a room length and a
// user light level are registered, decoded into a target lamp count and a
// target shade position, and the outputs ramp toward those targets by one
// unit every STEP_CYCLES clocks so that neither lamps nor shade jump.
//
// Ports
//   clk         in   1           rising-edge clock
//   rst_n       in   1           synchronous reset, active-low
//   tcode       in   4           0001 morning, 0010 noon, 0100 evening,
//                                1000 night, 0000 off; anything else invalid
//   ulight      in   LVL_W       user-requested shade level
//   lenght      in   LEN_W       room length (required lamp count)
//   wshade      out  LVL_W       current shade position (0 open, all-ones closed)
//   lightnum    out  CNT_W       number of lamps currently on
//   lightstate  out  MAX_LIGHTS  thermometer lamp enables, bit i = (i < lightnum)
//   busy        out  1           lightnum or wshade differs from its target
//   err         out  1           invalid tcode was registered on the previous edge
// ---------------------------------------------------------------------------
module lighting_ctrl_seq #(
  parameter int MAX_LIGHTS  = 16,
  parameter int LEN_W       = 4,
  parameter int LVL_W       = 4,
  parameter int STEP_CYCLES = 4,
  localparam int CNT_W      = $clog2(MAX_LIGHTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            tcode,
  input  logic [LVL_W-1:0]      ulight,
  input  logic [LEN_W-1:0]      lenght,
  output logic [LVL_W-1:0]      wshade,
  output logic [CNT_W-1:0]      lightnum,
  output logic [MAX_LIGHTS-1:0] lightstate,
  output logic                  busy,
  output logic                  err
);

  // Prescaler needs at least one bit even when every busy clock is a step.
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_CYCLES - 1);

  // Wide enough to hold both the raw length and MAX_LIGHTS plus a carry.
  localparam int WW = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;
  localparam logic [WW-1:0] MAX_W = WW'(MAX_LIGHTS);

  localparam logic [LVL_W-1:0] SHADE_CLOSED = {LVL_W{1'b1}};

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_MORNING = 3'd1,
    MODE_NOON    = 3'd2,
    MODE_EVENING = 3'd3,
    MODE_NIGHT   = 3'd4
  } mode_t;

  // Thermometer code: the lowest n bits set.
  function automatic logic [MAX_LIGHTS-1:0] therm(input logic [CNT_W-1:0] n);
    logic [MAX_LIGHTS-1:0] t;
    t = '0;
    for (int i = 0; i < MAX_LIGHTS; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

  // Registered state
  logic [3:0]            tcode_q,      tcode_d;
  logic [LVL_W-1:0]      ulight_q,     ulight_d;
  logic [LEN_W-1:0]      lenght_q,     lenght_d;
  mode_t                 mode_q,       mode_d;
  logic                  err_q,        err_d;
  logic [PW-1:0]         presc_q,      presc_d;
  logic [CNT_W-1:0]      lightnum_q,   lightnum_d;
  logic [LVL_W-1:0]      wshade_q,     wshade_d;
  logic [MAX_LIGHTS-1:0] lightstate_q, lightstate_d;

  // Combinational decode
  logic                  tcode_valid_s;
  mode_t                 mode_eff_s;
  logic [WW-1:0]         len_w_s;
  logic [WW-1:0]         lclamp_w_s;
  logic [WW-1:0]         half_w_s;
  logic [CNT_W-1:0]      lights_tgt_s;
  logic [LVL_W-1:0]      shade_tgt_s;
  logic                  busy_s;
  logic                  step_tick_s;

  // Decode the registered time code. An invalid code keeps the previous mode,
  // so the targets do not move while the code is bad.
  always_comb begin
    tcode_valid_s = 1'b1;
    mode_eff_s    = mode_q;
    case (tcode_q)
      4'b0000: mode_eff_s = MODE_OFF;
      4'b0001: mode_eff_s = MODE_MORNING;
      4'b0010: mode_eff_s = MODE_NOON;
      4'b0100: mode_eff_s = MODE_EVENING;
      4'b1000: mode_eff_s = MODE_NIGHT;
      default: begin
        tcode_valid_s = 1'b0;
        mode_eff_s    = mode_q;
      end
    endcase
  end

  // Clamp the room length to the number of lamps actually wired.
  always_comb begin
    len_w_s = WW'(lenght_q);
    if (len_w_s > MAX_W) begin
      lclamp_w_s = MAX_W;
    end else begin
      lclamp_w_s = len_w_s;
    end
    // Evening uses half the lamps, rounded up.
    half_w_s = (lclamp_w_s + WW'(1)) >> 1;
  end

  // Per-mode targets for lamp count and shade position.
  always_comb begin
    lights_tgt_s = '0;
    shade_tgt_s  = '0;
    case (mode_eff_s)
      MODE_OFF: begin
        lights_tgt_s = '0;
        shade_tgt_s  = '0;
      end
      MODE_MORNING: begin
        lights_tgt_s = '0;
        shade_tgt_s  = ulight_q;
      end
      MODE_NOON: begin
        lights_tgt_s = '0;
        shade_tgt_s  = ulight_q >> 1;
      end
      MODE_EVENING: begin
        lights_tgt_s = CNT_W'(half_w_s);
        shade_tgt_s  = SHADE_CLOSED;
      end
      MODE_NIGHT: begin
        lights_tgt_s = CNT_W'(lclamp_w_s);
        shade_tgt_s  = SHADE_CLOSED;
      end
      default: begin
        lights_tgt_s = '0;
        shade_tgt_s  = '0;
      end
    endcase
  end

  // Ramp status and step tick. The tick is the prescaler wrap, and since the
  // prescaler only runs while busy, the first step lands STEP_CYCLES clocks
  // after busy rises.
  always_comb begin
    busy_s      = (lightnum_q != lights_tgt_s) | (wshade_q != shade_tgt_s);
    step_tick_s = busy_s & (presc_q == PRESC_MAX);
  end

  // Next-state logic for inputs, mode, error flag, prescaler and ramp outputs.
  always_comb begin
    tcode_d      = tcode;
    ulight_d     = ulight;
    lenght_d     = lenght;
    mode_d       = mode_eff_s;
    err_d        = ~tcode_valid_s;
    presc_d      = presc_q;
    lightnum_d   = lightnum_q;
    wshade_d     = wshade_q;

    // Prescaler is not cleared on retarget, only when the ramp is complete.
    if (!busy_s) begin
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Lamps and shade each move one unit toward their own target; equality
    // holds them, so they can never overshoot or wrap.
    if (step_tick_s) begin
      if (lightnum_q < lights_tgt_s) begin
        lightnum_d = lightnum_q + CNT_W'(1);
      end else if (lightnum_q > lights_tgt_s) begin
        lightnum_d = lightnum_q - CNT_W'(1);
      end else begin
        lightnum_d = lightnum_q;
      end

      if (wshade_q < shade_tgt_s) begin
        wshade_d = wshade_q + LVL_W'(1);
      end else if (wshade_q > shade_tgt_s) begin
        wshade_d = wshade_q - LVL_W'(1);
      end else begin
        wshade_d = wshade_q;
      end
    end else begin
      lightnum_d = lightnum_q;
      wshade_d   = wshade_q;
    end

    // Lamp enables are derived from the next count so they always match it.
    lightstate_d = therm(lightnum_d);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcode_q      <= 4'b0000;
      ulight_q     <= '0;
      lenght_q     <= '0;
      mode_q       <= MODE_OFF;
      err_q        <= 1'b0;
      presc_q      <= '0;
      lightnum_q   <= '0;
      wshade_q     <= '0;
      lightstate_q <= '0;
    end else begin
      tcode_q      <= tcode_d;
      ulight_q     <= ulight_d;
      lenght_q     <= lenght_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      presc_q      <= presc_d;
      lightnum_q   <= lightnum_d;
      wshade_q     <= wshade_d;
      lightstate_q <= lightstate_d;
    end
  end

  assign wshade     = wshade_q;
  assign lightnum   = lightnum_q;
  assign lightstate = lightstate_q;
  assign busy       = busy_s;
  assign err        = err_q;

endmodule

// File: tb/tb_lighting_ctrl_seq.sv
// ---------------------------------------------------------------------------
// Bench for lighting_ctrl_seq: two instances (16 lamps / 4-clock steps and
// 8 lamps / 1-clock steps) share the same inputs. A reference model computes
// targets from the mode rules and ramps toward them each clock; every falling
// edge compares all outputs, and directed scenarios add fixed-value checks.
// ---------------------------------------------------------------------------
module tb_lighting_ctrl_seq;

  logic        clk;
  logic        rst_n;
  logic [3:0]  tcode;
  logic [3:0]  ulight;
  logic [3:0]  lenght;

  logic [3:0]  wshade_a;
  logic [4:0]  lightnum_a;
  logic [15:0] lightstate_a;
  logic        busy_a;
  logic        err_a;

  logic [3:0]  wshade_b;
  logic [3:0]  lightnum_b;
  logic [7:0]  lightstate_b;
  logic        busy_b;
  logic        err_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  lighting_ctrl_seq u_dut_a (
    .clk(clk), .rst_n(rst_n), .tcode(tcode), .ulight(ulight), .lenght(lenght),
    .wshade(wshade_a), .lightnum(lightnum_a), .lightstate(lightstate_a),
    .busy(busy_a), .err(err_a)
  );

  lighting_ctrl_seq #(.MAX_LIGHTS(8), .STEP_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tcode(tcode), .ulight(ulight), .lenght(lenght),
    .wshade(wshade_b), .lightnum(lightnum_b), .lightstate(lightstate_b),
    .busy(busy_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int maxl [2] = '{16, 8};
  int stp  [2] = '{4, 1};
  int m_tc, m_ul, m_len, m_mode, m_err;
  int m_ln [2];
  int m_sh [2];
  int m_ph [2];

  function automatic bit is_valid(input int tc);
    return (tc == 0) || (tc == 1) || (tc == 2) || (tc == 4) || (tc == 8);
  endfunction

  function automatic int eff_mode();
    return is_valid(m_tc) ? m_tc : m_mode;
  endfunction

  function automatic int lights_target(input int md, input int len, input int mx);
    int c;
    c = (len < mx) ? len : mx;
    if (md == 8) return c;
    if (md == 4) return (c + 1) / 2;
    return 0;
  endfunction

  function automatic int shade_target(input int md, input int ul);
    if (md == 1) return ul;
    if (md == 2) return ul / 2;
    if (md == 4 || md == 8) return 15;
    return 0;
  endfunction

  function automatic bit exp_busy(input int k);
    int md;
    md = eff_mode();
    return (m_ln[k] != lights_target(md, m_len, maxl[k])) ||
           (m_sh[k] != shade_target(md, m_ul));
  endfunction

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  always @(posedge clk) begin : model
    int md, lt, st;
    bit b;
    if (!rst_n) begin
      m_tc = 0; m_ul = 0; m_len = 0; m_mode = 0; m_err = 0;
      for (int k = 0; k < 2; k++) begin
        m_ln[k] = 0; m_sh[k] = 0; m_ph[k] = 0;
      end
    end else begin
      md = eff_mode();
      for (int k = 0; k < 2; k++) begin
        lt = lights_target(md, m_len, maxl[k]);
        st = shade_target(md, m_ul);
        b  = (m_ln[k] != lt) || (m_sh[k] != st);
        if (b && (m_ph[k] == stp[k] - 1)) begin
          m_ln[k] = toward(m_ln[k], lt);
          m_sh[k] = toward(m_sh[k], st);
        end
        m_ph[k] = b ? ((m_ph[k] + 1) % stp[k]) : 0;
      end
      m_err  = is_valid(m_tc) ? 0 : 1;
      m_mode = md;
      m_tc   = int'(tcode);
      m_ul   = int'(ulight);
      m_len  = int'(lenght);
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("a_lightnum",   lightnum_a,   m_ln[0]);
      check_eq("a_wshade",     wshade_a,     m_sh[0]);
      check_eq("a_lightstate", lightstate_a, (32'd1 << m_ln[0]) - 32'd1);
      check_eq("a_busy",       busy_a,       exp_busy(0));
      check_eq("a_err",        err_a,        m_err);
      check_eq("b_lightnum",   lightnum_b,   m_ln[1]);
      check_eq("b_wshade",     wshade_b,     m_sh[1]);
      check_eq("b_lightstate", lightstate_b, (32'd1 << m_ln[1]) - 32'd1);
      check_eq("b_busy",       busy_b,       exp_busy(1));
      check_eq("b_err",        err_b,        m_err);
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold;
    bit found;
    rst_n = 1'b0; tcode = 4'b0000; ulight = 4'd0; lenght = 4'd0;
    wait_neg(2);
    check_eq("rst_lightnum",   lightnum_a,   32'd0);
    check_eq("rst_lightstate", lightstate_a, 32'd0);
    check_eq("rst_wshade",     wshade_a,     32'd0);
    check_eq("rst_busy",       busy_a,       32'd0);
    check_eq("rst_err",        err_a,        32'd0);
    chk_en = 1'b1;

    // T1: night, length 9, ulight 13
    rst_n = 1'b1; tcode = 4'b1000; lenght = 4'd9; ulight = 4'd13;
    wait_neg(1);
    check_eq("t1_busy_rise", busy_a, 32'd1);
    check_eq("t1_no_step_yet", lightnum_a, 32'd0);
    wait_neg(35);
    check_eq("t1_lightnum_36", lightnum_a, 32'd8);
    wait_neg(1);
    check_eq("t1_lightnum_37", lightnum_a, 32'd9);
    check_eq("t1_lightstate", lightstate_a, 32'h01FF);
    wait_neg(23);
    check_eq("t1_busy_60", busy_a, 32'd1);
    wait_neg(1);
    check_eq("t1_wshade", wshade_a, 32'd15);
    check_eq("t1_busy_done", busy_a, 32'd0);

    // T2: evening
    tcode = 4'b0100;
    wait_neg(16);
    check_eq("t2_lightnum_16", lightnum_a, 32'd6);
    wait_neg(1);
    check_eq("t2_lightnum", lightnum_a, 32'd5);
    check_eq("t2_lightstate", lightstate_a, 32'h001F);
    check_eq("t2_wshade", wshade_a, 32'd15);
    check_eq("t2_busy", busy_a, 32'd0);

    // T3: morning, ulight 13
    tcode = 4'b0001;
    wait_neg(9);
    check_eq("t3_wshade", wshade_a, 32'd13);
    wait_neg(12);
    check_eq("t3_lightnum", lightnum_a, 32'd0);
    check_eq("t3_busy", busy_a, 32'd0);

    // T4: invalid code held three clocks in night steady state
    tcode = 4'b1000;
    wait_neg(70);
    tcode = 4'b0011;
    for (int m = 1; m <= 6; m++) begin
      wait_neg(1);
      if (m == 3) tcode = 4'b1000;
      check_eq("t4_err", err_a, (m >= 2 && m <= 4) ? 32'd1 : 32'd0);
      check_eq("t4_lightnum", lightnum_a, 32'd9);
      check_eq("t4_busy", busy_a, 32'd0);
    end

    // Noon with ulight 13 settles the shade at 6
    tcode = 4'b0010;
    wait_neg(80);
    check_eq("noon_wshade", wshade_a, 32'd6);
    check_eq("noon_lightnum", lightnum_a, 32'd0);

    // T5: reset mid-ramp
    tcode = 4'b1000;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      wait_neg(1);
      if (lightnum_a == 5'd4) found = 1'b1;
    end
    check_eq("t5_reach4", found, 32'd1);
    rst_n = 1'b0;
    wait_neg(1);
    check_eq("t5_lightnum", lightnum_a, 32'd0);
    check_eq("t5_lightstate", lightstate_a, 32'd0);
    check_eq("t5_wshade", wshade_a, 32'd0);
    check_eq("t5_busy", busy_a, 32'd0);
    check_eq("t5_err", err_a, 32'd0);
    rst_n = 1'b1;
    wait_neg(4);
    check_eq("t5_restart_hold", lightnum_a, 32'd0);
    wait_neg(1);
    check_eq("t5_restart_step", lightnum_a, 32'd1);

    // T6: length beyond the 8-lamp instance
    lenght = 4'd12;
    wait_neg(100);
    check_eq("t6_b_lightnum", lightnum_b, 32'd8);
    check_eq("t6_b_lightstate", lightstate_b, 32'h00FF);
    check_eq("t6_a_lightnum", lightnum_a, 32'd12);
    check_eq("t6_a_lightstate", lightstate_a, 32'h0FFF);

    // Randomized phase, checked every cycle against the model
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        wait_neg(1);
        rst_n = 1'b1;
      end
      case ($urandom_range(0, 5))
        0: tcode = 4'b0000;
        1: tcode = 4'b0001;
        2: tcode = 4'b0010;
        3: tcode = 4'b0100;
        4: tcode = 4'b1000;
        default: tcode = 4'($urandom_range(0, 15));
      endcase
      ulight = 4'($urandom_range(0, 15));
      lenght = 4'($urandom_range(0, 15));
      hold   = $urandom_range(1, 25);
      wait_neg(hold);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
